// File: rtl/inst_sequencer_if.sv
// Fetch/issue bus of the instruction sequencer: imem fetch port, ALU flags,
// and the valid/stall issue handshake towards the execute stage.
interface inst_sequencer_if #(
  parameter int INST_W = 8,
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              imem_valid;
  logic              flag_z;
  logic              flag_c;
  logic              flag_n;
  logic              stall;
  logic              issue_valid;
  logic [INST_W-1:0] issue_opcode;
  logic              issue_long;
  logic [ADDR_W-1:0] issue_target;
  logic              taken;
  logic [ADDR_W-1:0] pc;

  modport master (
    output imem_addr, issue_valid, issue_opcode, issue_long, issue_target, taken, pc,
    input  imem_data, imem_valid, flag_z, flag_c, flag_n, stall
  );

  modport slave (
    input  imem_addr, issue_valid, issue_opcode, issue_long, issue_target, taken, pc,
    output imem_data, imem_valid, flag_z, flag_c, flag_n, stall
  );
endinterface

// File: rtl/inst_sequencer.sv
// Byte-serial instruction fetch and sequencing: assembles long-form operands,
// resolves conditional jumps against ALU flags and issues one instruction at a time.
module inst_sequencer #(
  parameter int INST_W    = 8,
  parameter int EXT_BYTES = 1,
  parameter int ADDR_W    = 13,
  parameter int RESET_PC  = 0
) (
  input logic               clk,
  input logic               rst,
  inst_sequencer_if.master  bus
);
  localparam int COND_W = INST_W - 3;
  localparam int CAT_W  = COND_W + INST_W*EXT_BYTES;

  typedef enum logic [1:0] {FETCH_OP, FETCH_EXT, ISSUE} state_e;

  typedef struct packed {
    logic [INST_W-1:0] opcode;
    logic              is_long;
    logic [CAT_W-1:0]  acc;
  } inst_t;

  state_e            state_q, state_d;
  inst_t             inst_q, inst_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [COND_W-1:0] cond_q, cond_d;
  logic [1:0]        ext_cnt_q, ext_cnt_d;

  logic [2:0]        in_cls, op_cls;
  logic              in_long;
  logic [COND_W+1:0] cond_pad;
  logic              cond_true;
  logic              jump_taken;
  logic [ADDR_W-1:0] target;

  assign in_cls  = bus.imem_data[INST_W-1 -: 3];
  assign op_cls  = inst_q.opcode[INST_W-1 -: 3];
  assign in_long = !bus.imem_data[INST_W-1] || (in_cls == 3'b110);

  // Padding keeps cond_pad[2:1] addressable even when the condition register is only 2 bits wide.
  assign cond_pad = {2'b00, cond_q};

  always_comb begin
    cond_true = 1'b1;
    case (cond_pad[2:1])
      2'b00:   cond_true = 1'b1;
      2'b01:   cond_true = bus.flag_z;
      2'b10:   cond_true = bus.flag_c;
      default: cond_true = bus.flag_n;
    endcase
  end

  assign jump_taken = (state_q == ISSUE) && (op_cls == 3'b110) && cond_true;
  assign target     = ADDR_W'(inst_q.acc);

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    pc_d      = pc_q;
    cond_d    = cond_q;
    ext_cnt_d = ext_cnt_q;
    case (state_q)
      FETCH_OP: begin
        if (bus.imem_valid) begin
          inst_d.opcode  = bus.imem_data;
          inst_d.is_long = in_long;
          inst_d.acc     = in_long ? CAT_W'(bus.imem_data[INST_W-4:0]) : '0;
          pc_d           = pc_q + 1'b1;
          ext_cnt_d      = '0;
          state_d        = in_long ? FETCH_EXT : ISSUE;
        end
      end
      FETCH_EXT: begin
        if (bus.imem_valid) begin
          // Earliest byte ends up most significant after the last shift.
          inst_d.acc = {inst_q.acc[CAT_W-INST_W-1:0], bus.imem_data};
          pc_d       = pc_q + 1'b1;
          if (ext_cnt_q == 2'(EXT_BYTES-1)) state_d = ISSUE;
          else                              ext_cnt_d = ext_cnt_q + 1'b1;
        end
      end
      ISSUE: begin
        if (!bus.stall) begin
          if (jump_taken)         pc_d   = target;
          if (op_cls == 3'b111)   cond_d = inst_q.opcode[INST_W-4:0];
          state_d = FETCH_OP;
        end
      end
      default: state_d = FETCH_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_OP;
      inst_q    <= '0;
      pc_q      <= ADDR_W'(RESET_PC);
      cond_q    <= '0;
      ext_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_q      <= pc_d;
      cond_q    <= cond_d;
      ext_cnt_q <= ext_cnt_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.pc           = pc_q;
  assign bus.issue_valid  = (state_q == ISSUE);
  assign bus.issue_opcode = inst_q.opcode;
  assign bus.issue_long   = inst_q.is_long;
  assign bus.issue_target = target;
  assign bus.taken        = jump_taken;
endmodule

// File: tb/tb_inst_sequencer.sv
// Random and directed checks of inst_sequencer in two configurations against a
// transaction-level model of fetch, operand assembly and jump resolution.
`timescale 1ns/1ps
module tb_inst_sequencer;
  localparam int RST_PC = 'h100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_sequencer_if #(.INST_W(8), .ADDR_W(13)) bus_a();
  inst_sequencer_if #(.INST_W(8), .ADDR_W(16)) bus_b();

  inst_sequencer #(.INST_W(8), .EXT_BYTES(1), .ADDR_W(13), .RESET_PC(RST_PC))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  inst_sequencer #(.INST_W(8), .EXT_BYTES(2), .ADDR_W(16), .RESET_PC(RST_PC))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [7:0] mem [0:65535];
  logic valid, stall, fz, fc, fn;
  logic sel;

  assign bus_a.imem_data  = mem[{3'b000, bus_a.imem_addr}];
  assign bus_b.imem_data  = mem[bus_b.imem_addr];
  assign bus_a.imem_valid = valid;
  assign bus_b.imem_valid = valid;
  assign bus_a.stall = stall;
  assign bus_b.stall = stall;
  assign bus_a.flag_z = fz;
  assign bus_b.flag_z = fz;
  assign bus_a.flag_c = fc;
  assign bus_b.flag_c = fc;
  assign bus_a.flag_n = fn;
  assign bus_b.flag_n = fn;

  logic [15:0] obs_pc, obs_addr, obs_tgt;
  logic [7:0]  obs_op;
  logic        obs_valid, obs_long, obs_taken;
  assign obs_pc    = sel ? bus_b.pc           : {3'b000, bus_a.pc};
  assign obs_addr  = sel ? bus_b.imem_addr    : {3'b000, bus_a.imem_addr};
  assign obs_tgt   = sel ? bus_b.issue_target : {3'b000, bus_a.issue_target};
  assign obs_op    = sel ? bus_b.issue_opcode : bus_a.issue_opcode;
  assign obs_valid = sel ? bus_b.issue_valid  : bus_a.issue_valid;
  assign obs_long  = sel ? bus_b.issue_long   : bus_a.issue_long;
  assign obs_taken = sel ? bus_b.taken        : bus_a.taken;

  int n_cmp = 0;
  int n_bad = 0;
  int ext_n, amask;
  int pc_m;
  logic [4:0] cond_m;
  logic [7:0]  last_op;
  logic        last_long, last_taken;
  logic [15:0] last_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_taken(input logic [7:0] op, input logic [4:0] cnd,
                                     input logic z, input logic c, input logic n);
    if (op[7:5] != 3'b110) return 1'b0;
    case (cnd[2:1])
      2'd0:    return 1'b1;
      2'd1:    return z;
      2'd2:    return c;
      default: return n;
    endcase
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1; valid = 1'($urandom); stall = 1'($urandom);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0; valid = 1'b0;
    pc_m = RST_PC; cond_m = '0;
  endtask

  // One instruction from fetch to accept; fmode<0 randomizes flags, else {n,c,z}.
  task automatic exec_one(input int valid_pct, input int stall_n, input int fmode);
    logic [7:0] op;
    logic [2:0] fl;
    bit lng, tk;
    int need, got_b, tgt, cyc;
    op   = mem[pc_m];
    lng  = !op[7] || (op[7:5] == 3'b110);
    need = lng ? 1 + ext_n : 1;
    tgt  = 0;
    if (lng) begin
      tgt = int'(op[4:0]);
      for (int i = 1; i < need; i++) tgt = (tgt << 8) | int'(mem[(pc_m + i) & amask]);
      tgt = tgt & amask;
    end
    got_b = 0; cyc = 0;
    while (got_b < need) begin
      chk("fetch_pc", 32'(obs_pc), 32'((pc_m + got_b) & amask));
      chk("fetch_addr", 32'(obs_addr), 32'((pc_m + got_b) & amask));
      chk("fetch_nvalid", 32'(obs_valid), 32'd0);
      valid = ($urandom_range(99) < valid_pct);
      stall = 1'($urandom);
      {fn, fc, fz} = 3'($urandom);
      @(posedge clk); #1;
      if (valid) got_b++;
      cyc++;
      if (cyc > 200) begin
        chk("fetch_timeout", 32'(cyc), 32'd0);
        return;
      end
    end
    tk = 1'b0;
    for (int s = 0; s <= stall_n; s++) begin
      stall = (s < stall_n);
      fl = (fmode < 0) ? 3'($urandom) : 3'(fmode);
      {fn, fc, fz} = fl;
      valid = 1'($urandom);
      #1;
      tk = model_taken(op, cond_m, fz, fc, fn);
      chk("iss_valid", 32'(obs_valid), 32'd1);
      chk("iss_op", 32'(obs_op), 32'(op));
      chk("iss_long", 32'(obs_long), 32'(lng));
      chk("iss_tgt", 32'(obs_tgt), 32'(tgt));
      chk("iss_taken", 32'(obs_taken), 32'(tk));
      last_op = obs_op; last_long = obs_long; last_tgt = obs_tgt; last_taken = obs_taken;
      @(posedge clk); #1;
    end
    pc_m = tk ? tgt : ((pc_m + need) & amask);
    if (op[7:5] == 3'b111) cond_m = op[4:0];
    valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; {fn, fc, fz} = 3'b000;
    sel = 1'b0; ext_n = 1; amask = 'h1FFF;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem['h100] = 8'hA5; mem['h101] = 8'hC3; mem['h102] = 8'h45;
    mem['h345] = 8'hE2; mem['h346] = 8'hC1; mem['h347] = 8'h10;
    mem['h348] = 8'hC1; mem['h349] = 8'h10;
    mem['h110] = 8'h12; mem['h111] = 8'h34;

    do_reset(2);
    chk("rst_pc", 32'(obs_pc), 32'h100);
    chk("rst_valid", 32'(obs_valid), 32'd0);
    chk("rst_op", 32'(obs_op), 32'd0);
    chk("rst_long", 32'(obs_long), 32'd0);
    chk("rst_tgt", 32'(obs_tgt), 32'd0);
    chk("rst_taken", 32'(obs_taken), 32'd0);

    exec_one(100, 0, -1);
    chk("short_op", 32'(last_op), 32'hA5);
    chk("short_tgt", 32'(last_tgt), 32'd0);
    chk("short_pc", 32'(obs_pc), 32'h101);
    exec_one(100, 0, -1);
    chk("ujmp_tgt", 32'(last_tgt), 32'h345);
    chk("ujmp_taken", 32'(last_taken), 32'd1);
    chk("ujmp_pc", 32'(obs_pc), 32'h345);
    exec_one(100, 0, -1);
    exec_one(100, 0, 0);
    chk("cjmp_nt_taken", 32'(last_taken), 32'd0);
    chk("cjmp_nt_pc", 32'(obs_pc), 32'h348);
    exec_one(100, 0, 1);
    chk("cjmp_t_taken", 32'(last_taken), 32'd1);
    chk("cjmp_t_pc", 32'(obs_pc), 32'h110);
    exec_one(50, 3, -1);
    chk("stall_tgt", 32'(last_tgt), 32'h1234);
    chk("stall_pc", 32'(obs_pc), 32'h112);
    chk("stall_once", 32'(obs_valid), 32'd0);
    for (int k = 0; k < 150; k++) exec_one(70, $urandom_range(0, 2), -1);

    sel = 1'b1; ext_n = 2; amask = 'hFFFF;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem['h100] = 8'hC0; mem['h101] = 8'hFF; mem['h102] = 8'hFF;
    mem['hFFFF] = 8'h1F; mem['h0000] = 8'hAB; mem['h0001] = 8'hCD;
    mem['h0002] = 8'h05;
    do_reset(2);
    chk("b_rst_pc", 32'(obs_pc), 32'h100);
    exec_one(100, 0, -1);
    chk("b_jmp_pc", 32'(obs_pc), 32'hFFFF);
    exec_one(100, 1, -1);
    chk("wrap_tgt", 32'(last_tgt), 32'hABCD);
    chk("wrap_long", 32'(last_long), 32'd1);
    chk("wrap_pc", 32'(obs_pc), 32'h0002);

    valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midext_nvalid", 32'(obs_valid), 32'd0);
    chk("midext_pc", 32'(obs_pc), 32'h0004);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    pc_m = RST_PC; cond_m = '0;
    for (int k = 0; k < 3; k++) begin
      chk("midext_rst_valid", 32'(obs_valid), 32'd0);
      chk("midext_rst_pc", 32'(obs_pc), 32'h100);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 150; k++) exec_one(70, $urandom_range(0, 2), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
Parametrised instruction fetch/sequencing unit for the multi-cycle 8-bit core family. It fetches variable-length instructions byte by byte from instruction memory and assembles long-form instructions (one opcode byte plus EXT_BYTES extension bytes) into a full address operand. It evaluates conditional jumps against the ALU flags and a latched condition register, steers the PC, and presents one decoded instruction at a time to the execute stage through a valid/stall handshake.

Parameters:
INST_W, 8, instruction/memory byte width in bits (>=5).
EXT_BYTES, 1, number of extension bytes following a long opcode (1..3).
ADDR_W, 13, PC/target width; must satisfy ADDR_W <= (INST_W-3) + INST_W*EXT_BYTES.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
imem_addr  out  ADDR_W  fetch address; always equals pc.
imem_data  in  INST_W  byte at imem_addr.
imem_valid  in  1  imem_data valid this cycle; 0 = fetch wait.
flag_z  in  1  zero flag from ALU.
flag_c  in  1  carry flag from ALU.
flag_n  in  1  negative flag from ALU.
stall  in  1  execute stage not ready; holds the issued instruction.
issue_valid  out  1  instruction presented to execute.
issue_opcode  out  INST_W  opcode byte of the issued instruction.
issue_long  out  1  issued instruction is long-form.
issue_target  out  ADDR_W  assembled operand address (0 for short instructions).
taken  out  1  jump taken; valid with issue_valid.
pc  out  ADDR_W  current fetch PC.

Behaviour:
- Opcode class = opcode[INST_W-1:INST_W-3].
  - Long form: opcode MSB = 0, or class = 110 (jump).
  - Short form: all other opcodes.
  - Class 111 is a condition-register load: cond_reg (INST_W-3 bits) <= opcode[INST_W-4:0] when the instruction is accepted.
- Jump condition is cond_reg[2:1]: 00 always; 01 flag_z; 10 flag_c; 11 flag_n.
  - taken = (class==110) && condition true, evaluated combinationally from current flags and cond_reg while in ISSUE.
- Target assembly: {opcode[INST_W-4:0], ext byte 0, ..., ext byte EXT_BYTES-1}. Earliest byte is most significant. Truncate to the low ADDR_W bits, or zero-extend if the concatenation is narrower.
- States: FETCH_OP, FETCH_EXT, ISSUE. A 2-bit ext_cnt counter runs in FETCH_EXT.
  - FETCH_OP, imem_valid=1: latch opcode; pc <= pc+1. Long form -> FETCH_EXT with ext_cnt=0. Short form -> ISSUE.
  - FETCH_OP, imem_valid=0: hold all state.
  - FETCH_EXT, imem_valid=1: shift imem_data into the target accumulator; pc <= pc+1. If ext_cnt==EXT_BYTES-1 -> ISSUE, else ext_cnt+1.
  - FETCH_EXT, imem_valid=0: hold.
  - ISSUE: issue_valid=1; opcode, long flag and target held stable.
  - ISSUE, stall=1: remain in ISSUE. Flags may change and taken follows them.
  - ISSUE, stall=0 (accept): if taken, pc <= issue_target; if class 111, load cond_reg; -> FETCH_OP.
- PC increments wrap modulo 2^ADDR_W. A jump to the current PC is legal.
- Latency with imem_valid held at 1: a short opcode fetched in cycle N issues in cycle N+1; a long opcode issues in cycle N+1+EXT_BYTES. Minimum throughput is 2 cycles per short instruction.
- Reset (sync, highest priority, overrides accept and fetch):
  - pc = RESET_PC; state = FETCH_OP; cond_reg = 0; ext_cnt = 0.
  - issue_valid = 0; issue_opcode = 0; issue_long = 0; issue_target = 0; taken = 0.
  - Reset mid-fetch or mid-issue discards the partial instruction without issuing it.
- cond_reg loaded by a class 111 instruction affects only later jumps, never the instruction being accepted.
- issue_target for short instructions is 0.

Test Plan:
- Reset: assert rst 2 cycles with RESET_PC=0x0100 -> pc=0x0100, issue_valid=0, all outputs 0, cond_reg=0.
- Short issue: imem 0x0000=0xA5, imem_valid=1, stall=0 -> issue_valid one cycle after the fetch with opcode 0xA5, issue_long=0, target=0; pc steps 0x0000->0x0001.
- Unconditional jump: cond_reg=0, imem 0x0000=0xC3, 0x0001=0x45 -> issue_long=1, target=0x0345, taken=1; next fetch at 0x0345.
- Conditional jump: load 0xE2 (cond=Z) then jump 0xC1,0x10 with flag_z=0 -> taken=0, next pc=sequential; repeat with flag_z=1 -> pc=0x0110.
- Handshake and wait: hold stall=1 for 3 cycles in ISSUE, then toggle imem_valid 1/0 during FETCH_EXT -> outputs stable while stalled; each ext byte is captured only on a valid cycle; issue occurs exactly once.
- Wrap and width: EXT_BYTES=2, ADDR_W=16; long opcode 0x1F at 0xFFFF with ext bytes 0xAB,0xCD -> pc wraps 0xFFFF->0x0000->0x0001, target=0xABCD (high opcode bits truncated); rst asserted in FETCH_EXT -> no issue, pc=RESET_PC.
